// File: rtl/seq_detector_param_pkg.sv
// Shared definitions for the parametrised serial sequence detector.
//   DEF_LEN / DEF_PATTERN / DEF_CNT_W : elaboration defaults for the top
//   clamp_len                         : maps a requested run-time length onto
//                                       the legal range 2..max_len
package seq_detector_param_pkg;

  localparam int unsigned DEF_LEN     = 4;
  localparam logic [3:0]  DEF_PATTERN = 4'b0101;
  localparam int unsigned DEF_CNT_W   = 8;

  // 0 or anything above max_len selects the full length; 1 is too short to be
  // a meaningful pattern and is widened to 2.
  function automatic int unsigned clamp_len(input int unsigned req,
                                            input int unsigned max_len);
    if (req == 0 || req > max_len) return max_len;
    else if (req == 1)             return 2;
    else                           return req;
  endfunction

endpackage

// File: rtl/seq_detector_param_match_window.sv
// seq_match_window: serial shift register plus fill counter for the detector.
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   flush     : drop partial progress (fill <= 0), window contents kept
//   shift     : accept the bit on 'in' this cycle
//   in        : serial data bit
//   overlap   : on a hit, keep fill at len_r (1) or restart from 0 (0)
//   pat_r     : active pattern, right-aligned
//   len_r     : active pattern length (2..LEN)
//   hit       : combinational, the bit on 'in' completes a match this cycle
//   fill      : bits currently held toward a match
module seq_match_window #(
  parameter int unsigned LEN    = 4,
  parameter int unsigned FILL_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              shift,
  input  logic              in,
  input  logic              overlap,
  input  logic [LEN-1:0]    pat_r,
  input  logic [FILL_W-1:0] len_r,
  output logic              hit,
  output logic [FILL_W-1:0] fill
);

  // Only LEN-1 history bits need storing: together with the incoming bit they
  // form the full LEN-bit comparison window.
  logic [LEN-2:0]    window;
  logic [LEN-1:0]    nwin;
  logic [FILL_W-1:0] nfill;
  logic              mism;

  always_comb begin
    nwin  = {window, in};
    nfill = (fill >= len_r) ? len_r : fill + FILL_W'(1);
    mism  = 1'b0;
    for (int unsigned i = 0; i < LEN; i++) begin
      if (i < 32'(len_r)) mism = mism | (nwin[i] ^ pat_r[i]);
    end
    hit = (nfill == len_r) && !mism;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      window <= '0;
      fill   <= '0;
    end else if (flush) begin
      fill <= '0;
    end else if (shift) begin
      window <= nwin[LEN-2:0];
      fill   <= (hit && !overlap) ? '0 : nfill;
    end
  end

endmodule

// File: rtl/seq_detector_param.sv
// seq_detector_param: run-time programmable serial bit-sequence detector.
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   in_valid, in : qualified serial data bit
//   overlap      : 1 = overlapping matches, 0 = restart after each match
//   clear        : drop partial progress and zero the match counter
//   cfg_load     : load cfg_pattern / cfg_len (clamped) as the active pattern
//   match        : registered one-cycle pulse after the completing bit
//   match_cnt    : saturating match count; cnt_sat flags all ones
//   fill         : bits currently held toward a match
// Per-cycle priority: rst > cfg_load > clear > in_valid.
module seq_detector_param
  import seq_detector_param_pkg::*;
#(
  parameter int unsigned    LEN     = DEF_LEN,
  parameter logic [LEN-1:0] PATTERN = DEF_PATTERN,
  parameter int unsigned    CNT_W   = DEF_CNT_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic                     in,
  input  logic                     overlap,
  input  logic                     clear,
  input  logic                     cfg_load,
  input  logic [LEN-1:0]           cfg_pattern,
  input  logic [$clog2(LEN+1)-1:0] cfg_len,
  output logic                     match,
  output logic [CNT_W-1:0]         match_cnt,
  output logic                     cnt_sat,
  output logic [$clog2(LEN+1)-1:0] fill
);

  localparam int unsigned FILL_W = $clog2(LEN+1);

  logic [LEN-1:0]    pat_r;
  logic [FILL_W-1:0] len_r;
  logic              flush;
  logic              shift;
  logic              hit;

  // A load or clear in the same cycle as a valid bit discards that bit.
  assign flush   = cfg_load | clear;
  assign shift   = in_valid & ~flush;
  assign cnt_sat = &match_cnt;

  seq_match_window #(
    .LEN    (LEN),
    .FILL_W (FILL_W)
  ) u_window (
    .clk     (clk),
    .rst     (rst),
    .flush   (flush),
    .shift   (shift),
    .in      (in),
    .overlap (overlap),
    .pat_r   (pat_r),
    .len_r   (len_r),
    .hit     (hit),
    .fill    (fill)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      pat_r <= PATTERN;
      len_r <= FILL_W'(LEN);
    end else if (cfg_load) begin
      pat_r <= cfg_pattern;
      len_r <= FILL_W'(clamp_len(32'(cfg_len), LEN));
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      match     <= 1'b0;
      match_cnt <= '0;
    end else if (shift) begin
      match <= hit;
      if (hit && !cnt_sat) match_cnt <= match_cnt + CNT_W'(1);
    end else begin
      match <= 1'b0;
    end
  end

endmodule

// File: tb/tb_seq_detector_param.sv
module tb_seq_detector_param;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       in_valid = 1'b0;
  logic       in = 1'b0;
  logic       overlap = 1'b0;
  logic       clear = 1'b0;
  logic       cfg_load = 1'b0;
  logic [3:0] cfg_pattern = '0;
  logic [2:0] cfg_len = '0;

  logic       match0, sat0, match1, sat1;
  logic [7:0] cnt0;
  logic [1:0] cnt1;
  logic [2:0] fill0, fill1;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  seq_detector_param dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in(in), .overlap(overlap),
    .clear(clear), .cfg_load(cfg_load), .cfg_pattern(cfg_pattern),
    .cfg_len(cfg_len), .match(match0), .match_cnt(cnt0), .cnt_sat(sat0),
    .fill(fill0)
  );

  seq_detector_param #(.LEN(4), .PATTERN(4'b1111), .CNT_W(2)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in(in), .overlap(overlap),
    .clear(clear), .cfg_load(cfg_load), .cfg_pattern(cfg_pattern),
    .cfg_len(cfg_len), .match(match1), .match_cnt(cnt1), .cnt_sat(sat1),
    .fill(fill1)
  );

  // Reference model: the detector seen as "the last hl received bits since
  // the last restart", compared numerically against the pattern value.
  typedef struct {
    int unsigned pat, len, hist, hl, cnt, cmax, rpat;
  } mdl_t;

  typedef struct {
    int unsigned mt, cnt, fill, sat;
  } exp_t;

  mdl_t m[2];
  exp_t q0[$];
  exp_t q1[$];

  task automatic mstep(input int k, input bit r, input bit ld, input bit clr,
                       input bit v, input bit b, input bit ov,
                       input int unsigned cp, input int unsigned cl,
                       output exp_t e);
    int unsigned mask;
    bit hitm;
    hitm = 0;
    if (r) begin
      m[k].pat = m[k].rpat; m[k].len = 4;
      m[k].hist = 0; m[k].hl = 0; m[k].cnt = 0;
    end else if (ld) begin
      m[k].pat = cp;
      m[k].len = (cl == 0 || cl > 4) ? 4 : (cl == 1 ? 2 : cl);
      m[k].hl = 0; m[k].cnt = 0;
    end else if (clr) begin
      m[k].hl = 0; m[k].cnt = 0;
    end else if (v) begin
      m[k].hist = (m[k].hist * 2 + b) % 16;
      if (m[k].hl < m[k].len) m[k].hl++;
      mask = (1 << m[k].len) - 1;
      hitm = (m[k].hl == m[k].len) && ((m[k].hist & mask) == (m[k].pat & mask));
      if (hitm) begin
        if (m[k].cnt < m[k].cmax) m[k].cnt++;
        if (!ov) m[k].hl = 0;
      end
    end
    e.mt = hitm; e.cnt = m[k].cnt; e.fill = m[k].hl;
    e.sat = (m[k].cnt == m[k].cmax);
  endtask

  task automatic drive(input bit r, input bit ld, input bit clr, input bit v,
                       input bit b, input bit ov, input int unsigned cp,
                       input int unsigned cl);
    exp_t e;
    @(negedge clk);
    rst = r; cfg_load = ld; clear = clr; in_valid = v; in = b; overlap = ov;
    cfg_pattern = 4'(cp); cfg_len = 3'(cl);
    mstep(0, r, ld, clr, v, b, ov, cp, cl, e); q0.push_back(e);
    mstep(1, r, ld, clr, v, b, ov, cp, cl, e); q1.push_back(e);
  endtask

  task automatic bitv(input bit b, input bit ov);
    drive(0, 0, 0, 1, b, ov, 0, 0);
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_rst();
    drive(1, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic chk(input string name, input int unsigned act, input int unsigned req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: every registered output update is compared with the next
  // expectation queued by the stimulus side.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q0.size() > 0) begin
        e = q0.pop_front();
        chk("dut0.match", 32'(match0), e.mt);
        chk("dut0.match_cnt", 32'(cnt0), e.cnt);
        chk("dut0.fill", 32'(fill0), e.fill);
        chk("dut0.cnt_sat", 32'(sat0), e.sat);
      end
      if (q1.size() > 0) begin
        e = q1.pop_front();
        chk("dut1.match", 32'(match1), e.mt);
        chk("dut1.match_cnt", 32'(cnt1), e.cnt);
        chk("dut1.fill", 32'(fill1), e.fill);
        chk("dut1.cnt_sat", 32'(sat1), e.sat);
      end
    end
  end

  initial begin
    bit seq[];
    bit r, ld, clr, v;
    int unsigned x;
    m[0] = '{pat: 5, len: 4, hist: 0, hl: 0, cnt: 0, cmax: 255, rpat: 5};
    m[1] = '{pat: 15, len: 4, hist: 0, hl: 0, cnt: 0, cmax: 3, rpat: 15};

    // Reset state
    do_rst();
    do_rst();

    // Overlapping 010101: matches after bits 4 and 6
    seq = '{0, 1, 0, 1, 0, 1};
    foreach (seq[i]) bitv(seq[i], 1);

    // Non-overlapping 01010101: matches after bits 4 and 8 only
    do_rst();
    seq = '{0, 1, 0, 1, 0, 1, 0, 1};
    foreach (seq[i]) bitv(seq[i], 0);

    // Gaps of 3 idle cycles between bits
    do_rst();
    seq = '{0, 1, 0, 1};
    foreach (seq[i]) begin
      bitv(seq[i], 1);
      repeat (3) idle();
    end

    // Reset mid-pattern, then clear mid-pattern
    do_rst();
    bitv(0, 1); bitv(1, 1); bitv(0, 1);
    do_rst();
    bitv(1, 1);
    bitv(0, 1); bitv(1, 1); bitv(0, 1);
    drive(0, 0, 1, 1, 1, 1, 0, 0);
    bitv(1, 1);

    // Reprogram to 3-bit 110, then cfg_len=0 selects the full length
    do_rst();
    seq = '{0, 1, 0, 1};
    foreach (seq[i]) bitv(seq[i], 1);
    drive(0, 1, 0, 1, 1, 1, 4'b0110, 3);
    bitv(1, 1); bitv(1, 1); bitv(0, 1);
    drive(0, 1, 0, 0, 0, 1, 4'b0101, 0);
    seq = '{0, 1, 0, 1};
    foreach (seq[i]) bitv(seq[i], 1);
    drive(0, 1, 0, 0, 0, 1, 4'b0011, 1);
    bitv(0, 1); bitv(1, 1); bitv(1, 1);

    // Counter saturation: dut1 uses 1111 with a 2-bit counter
    do_rst();
    repeat (8) bitv(1, 1);

    // Randomised traffic
    do_rst();
    for (int n = 0; n < 3000; n++) begin
      x   = $urandom_range(0, 99);
      r   = (x == 0);
      ld  = (x >= 1 && x <= 3);
      clr = (x >= 4 && x <= 6);
      v   = ($urandom_range(0, 9) < 7);
      drive(r, ld, clr, v, 1'($urandom), 1'($urandom),
            $urandom_range(0, 15), $urandom_range(0, 7));
    end
    idle();

    for (int i = 0; i < 10 && (q0.size() > 0 || q1.size() > 0); i++) @(negedge clk);
    checks++;
    if (q0.size() > 0 || q1.size() > 0) begin
      failures++;
      $display("FAIL drain pending=%0d required=0", q0.size() + q1.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
